// File: rtl/sensor_ctrl_if.sv
// Sensor-capture bus: wrapper register/readback signals plus the sensor request/sample handshake.
// The DUT uses the slave modport; the wrapper/sensor side (or a bench) uses master.
interface sensor_ctrl_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic              sctrl_en;
  logic              sctrl_clear;
  logic [ADDR_W-1:0] sctrl_addr;
  logic [DATA_W-1:0] sctrl_out;
  logic              sctrl_interrupt;
  logic              sensor_en;
  logic              sensor_ready;
  logic [DATA_W-1:0] sensor_out;

  modport slave (
    input  sctrl_en,
    input  sctrl_clear,
    input  sctrl_addr,
    output sctrl_out,
    output sctrl_interrupt,
    output sensor_en,
    input  sensor_ready,
    input  sensor_out
  );

  modport master (
    output sctrl_en,
    output sctrl_clear,
    output sctrl_addr,
    input  sctrl_out,
    input  sctrl_interrupt,
    input  sensor_en,
    output sensor_ready,
    output sensor_out
  );
endinterface

// File: rtl/sensor_ctrl.sv
// Sensor capture controller: fills a DEPTH-word buffer from the sensor, flags full, serves word reads.
// Define SCTRL_MEM_RESET_EN to give the buffer a reset to zero (flop-based); otherwise it is SRAM-mappable.
module sensor_ctrl #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic         ACLK,
  input  logic         ARESETn,
  sensor_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    FULL    = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(DEPTH);

  state_t            state, state_nxt;
  logic [ADDR_W:0]   cnt, cnt_nxt;
  logic              wr_en;
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Clear wins over everything, including a sample arriving in the same cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    wr_en     = 1'b0;
    if (bus.sctrl_clear) begin
      cnt_nxt   = '0;
      state_nxt = bus.sctrl_en ? CAPTURE : IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.sctrl_en && (cnt < CNT_FULL))
            state_nxt = CAPTURE;
        end
        CAPTURE: begin
          if (bus.sensor_ready) begin
            wr_en   = 1'b1;
            cnt_nxt = cnt + 1'b1;
          end
          // The final write reaches FULL even if enable drops in the same cycle.
          if (bus.sensor_ready && (cnt == CNT_LAST))
            state_nxt = FULL;
          else if (!bus.sctrl_en)
            state_nxt = IDLE;
        end
        FULL:    state_nxt = FULL;
        default: state_nxt = IDLE;
      endcase
    end
  end

`ifdef SCTRL_MEM_RESET_EN
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (wr_en) begin
      mem[cnt[ADDR_W-1:0]] <= bus.sensor_out;
    end
  end
`else
  always_ff @(posedge ACLK) begin
    if (wr_en)
      mem[cnt[ADDR_W-1:0]] <= bus.sensor_out;
  end
`endif

  assign bus.sensor_en       = (state == CAPTURE);
  assign bus.sctrl_interrupt = (state == FULL);
  assign bus.sctrl_out       = mem[bus.sctrl_addr];

endmodule
